// File: rtl/byte_word_packer_pkg.sv
// Shared constants and lane helpers for the byte/word packer and its companion unpacker.
package byte_word_packer_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int BYTES_DEF  = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int MAX_LANES  = 32;

    // One-hot lane select for lane idx; callers size-cast down to their lane count.
    function automatic logic [MAX_LANES-1:0] lane_onehot(input int unsigned idx);
        logic [MAX_LANES-1:0] v;
        v = {{(MAX_LANES-1){1'b0}}, 1'b1};
        return v << idx;
    endfunction

endpackage

// File: rtl/byte_word_packer_out_reg.sv
// Output holding register with a valid/ready handshake; a load may coincide with a handoff.
module byte_word_packer_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_load_ok,
    output logic              o_handoff,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;

    // Room for a new word whenever the slot is empty or is being drained this cycle.
    assign o_load_ok = ~r_valid | i_ready;
    assign o_handoff = r_valid & i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (o_handoff) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into words (lane k = bits [k*BYTE_W +: BYTE_W]),
// with byte_last flushing a partial word under a keep mask.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int BYTES  = BYTES_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BYTE_W-1:0]       byte_data,
    input  logic                    byte_valid,
    input  logic                    byte_last,
    output logic                    byte_ready,
    output logic [BYTE_W*BYTES-1:0] word_data,
    output logic [BYTES-1:0]        word_keep,
    output logic                    word_last,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [CNT_W-1:0]        word_cnt
);

    localparam int WORD_W = BYTE_W * BYTES;
    localparam int IDX_W  = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [WORD_W-1:0] r_acc;
    logic [BYTES-1:0]  r_keep;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_complete;
    logic              w_load_ok;
    logic              w_handoff;
    logic [BYTES-1:0]  w_lane_sel;
    logic [BYTES-1:0]  w_keep_next;
    logic [WORD_W-1:0] w_acc_next;

    assign byte_ready  = w_load_ok;
    assign w_accept    = byte_valid & w_load_ok;
    assign w_complete  = w_accept & ((r_idx == LAST_IDX) | byte_last);
    assign w_lane_sel  = BYTES'(lane_onehot(32'(r_idx)));
    assign w_keep_next = r_keep | w_lane_sel;

    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < BYTES; k++) begin
            if (w_lane_sel[k]) begin
                w_acc_next[k*BYTE_W +: BYTE_W] = byte_data;
            end
        end
    end

    // Accumulator clears on completion so unwritten lanes of the next word read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_keep <= '0;
            r_idx  <= '0;
        end else if (w_complete) begin
            r_acc  <= '0;
            r_keep <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_acc  <= w_acc_next;
            r_keep <= w_keep_next;
            r_idx  <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_handoff) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign word_cnt = r_cnt;

    byte_word_packer_out_reg #(
        .DATA_W (WORD_W),
        .KEEP_W (BYTES)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_complete),
        .i_data    (w_acc_next),
        .i_keep    (w_keep_next),
        .i_last    (byte_last),
        .i_ready   (word_ready),
        .o_load_ok (w_load_ok),
        .o_handoff (w_handoff),
        .o_valid   (word_valid),
        .o_data    (word_data),
        .o_keep    (word_keep),
        .o_last    (word_last)
    );

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: queue-based packet model plus literal spot checks.
module tb_byte_word_packer;

    localparam int BYTE_W = 8;
    localparam int BYTES  = 4;
    localparam int CNT_W  = 4;
    localparam int WORD_W = BYTE_W * BYTES;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [BYTE_W-1:0] byte_data = '0;
    logic              byte_valid = 1'b0;
    logic              byte_last = 1'b0;
    logic              byte_ready;
    logic [WORD_W-1:0] word_data;
    logic [BYTES-1:0]  word_keep;
    logic              word_last;
    logic              word_valid;
    logic              word_ready = 1'b1;
    logic [CNT_W-1:0]  word_cnt;

    int n_vec = 0;
    int n_err = 0;

    byte_word_packer #(
        .BYTE_W (BYTE_W),
        .BYTES  (BYTES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .word_data  (word_data),
        .word_keep  (word_keep),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: bytes collected in a queue, word formed from it when full or on byte_last.
    logic [BYTE_W-1:0] m_bytes[$];
    logic              m_valid = 1'b0;
    logic [WORD_W-1:0] m_data = '0;
    int                m_keep = 0;
    logic              m_last = 1'b0;
    int                m_cnt = 0;

    always @(posedge clk or posedge reset) begin : model
        bit hand, acc, done;
        if (reset) begin
            m_bytes.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_keep  = 0;
            m_last  = 1'b0;
            m_cnt   = 0;
        end else begin
            done = 0;
            hand = m_valid && word_ready;
            acc  = byte_valid && (!m_valid || word_ready);
            if (hand) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (acc) begin
                m_bytes.push_back(byte_data);
                if (m_bytes.size() == BYTES || byte_last) begin
                    m_data = '0;
                    foreach (m_bytes[i]) m_data |= WORD_W'(m_bytes[i]) << (i * BYTE_W);
                    m_keep  = (1 << m_bytes.size()) - 1;
                    m_last  = byte_last;
                    m_valid = 1'b1;
                    m_bytes.delete();
                    done = 1;
                end
            end
            if (hand && !done) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("m_valid", 64'(word_valid), 64'(m_valid));
            check("m_ready", 64'(byte_ready), 64'(!m_valid || word_ready));
            check("m_cnt",   64'(word_cnt),   64'(m_cnt));
            if (m_valid) begin
                check("m_data", 64'(word_data), 64'(m_data));
                check("m_keep", 64'(word_keep), 64'(m_keep));
                check("m_last", 64'(word_last), 64'(m_last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [BYTE_W-1:0] d, input logic l);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
    endtask

    task automatic idle();
        byte_valid = 1'b0;
        byte_data  = '0;
        byte_last  = 1'b0;
    endtask

    // Reset lands between clock edges; its effect must be visible before the next edge.
    task automatic mid_cycle_reset(input string tag);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check({tag, "_valid"}, 64'(word_valid), 64'd0);
        check({tag, "_ready"}, 64'(byte_ready), 64'd1);
        check({tag, "_cnt"},   64'(word_cnt),   64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        idle();
        word_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_ready", 64'(byte_ready), 64'd1);
        check("rst_data",  64'(word_data),  64'd0);
        check("rst_keep",  64'(word_keep),  64'd0);
        check("rst_last",  64'(word_last),  64'd0);
        check("rst_cnt",   64'(word_cnt),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Full word
        put(8'h11, 0); step();
        put(8'h22, 0); step();
        put(8'h33, 0); step();
        put(8'h44, 0); step();
        idle();
        check("full_valid", 64'(word_valid), 64'd1);
        check("full_data",  64'(word_data),  64'h44332211);
        check("full_keep",  64'(word_keep),  64'hF);
        check("full_last",  64'(word_last),  64'd0);
        step();
        check("full_drop", 64'(word_valid), 64'd0);
        check("full_cnt",  64'(word_cnt),   64'd1);

        // Partial flush, then a single-byte packet landing in lane 0 back-to-back
        put(8'hAA, 0); step();
        put(8'hBB, 1); step();
        check("part_data", 64'(word_data), 64'h0000BBAA);
        check("part_keep", 64'(word_keep), 64'h3);
        check("part_last", 64'(word_last), 64'd1);
        put(8'hCC, 1); step();
        idle();
        check("lane0_valid", 64'(word_valid), 64'd1);
        check("lane0_data",  64'(word_data),  64'h000000CC);
        check("lane0_keep",  64'(word_keep),  64'h1);
        check("lane0_cnt",   64'(word_cnt),   64'd2);
        step();
        check("part_cnt", 64'(word_cnt), 64'd3);

        // Backpressure
        word_ready = 1'b0;
        put(8'h01, 0); step();
        put(8'h02, 0); step();
        put(8'h03, 0); step();
        put(8'h04, 0); step();
        put(8'h55, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 64'(byte_ready), 64'd0);
            check("bp_data",  64'(word_data),  64'h04030201);
            check("bp_keep",  64'(word_keep),  64'hF);
            step();
        end
        word_ready = 1'b1;
        #1;
        check("bp_release", 64'(byte_ready), 64'd1);
        step();
        check("bp_handoff", 64'(word_cnt), 64'd4);
        put(8'h66, 0); step();
        put(8'h77, 0); step();
        put(8'h88, 0); step();
        idle();
        check("bp_next", 64'(word_data), 64'h88776655);
        step();

        // Reset with a pending word, then with a partial word
        word_ready = 1'b0;
        put(8'hA1, 0); step();
        put(8'hA2, 0); step();
        put(8'hA3, 0); step();
        put(8'hA4, 0); step();
        idle();
        mid_cycle_reset("rst_pend");
        step();
        word_ready = 1'b1;
        put(8'hB1, 0); step();
        idle();
        mid_cycle_reset("rst_part");
        step();

        // Streaming with no bubbles
        for (int i = 1; i <= 12; i++) begin
            put(8'(i), 0);
            check("strm_ready", 64'(byte_ready), 64'd1);
            step();
            if (i == 4)  check("strm_w0", 64'(word_data), 64'h04030201);
            if (i == 8)  check("strm_w1", 64'(word_data), 64'h08070605);
            if (i == 12) check("strm_w2", 64'(word_data), 64'h0C0B0A09);
        end
        idle();
        step();
        check("strm_cnt", 64'(word_cnt), 64'd3);

        // Counter wrap from zero: 17 single-byte packets
        mid_cycle_reset("rst_wrap");
        step();
        for (int i = 0; i < 17; i++) begin
            put(8'(8'h20 + i), 1);
            step();
        end
        idle();
        step();
        check("wrap_cnt", 64'(word_cnt), 64'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Reassembles a stream of 8-bit bytes into 32-bit words. It is the inverse of the existing word-to-byte-register split, which uses lane k = bits [8k +: 8].
- Sits between a byte-wide source (UART/SPI receive path) and the 32-bit datapath.
- Valid/ready handshake on both sides.
- A partial word can be flushed with a keep mask.

Parameters:
- BYTE_W, 8, width of one input byte.
- BYTES, 4, bytes per output word; output width = BYTE_W*BYTES; must be >= 2.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- byte_data  in  BYTE_W  input byte.
- byte_valid  in  1  byte_data is valid.
- byte_last  in  1  marks the final byte of a packet; forces the word to be emitted. Qualified by byte_valid.
- byte_ready  out  1  packer accepts a byte this cycle.
- word_data  out  BYTE_W*BYTES  assembled word.
- word_keep  out  BYTES  per-lane valid mask.
- word_last  out  1  word closes a packet.
- word_valid  out  1  word outputs are valid.
- word_ready  in  1  sink accepts the word.
- word_cnt  out  CNT_W  count of words handed off; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state clears on reset assertion, independent of clk.
- Reset values: byte_ready=1, word_valid=0, word_data=0, word_keep=0, word_last=0, word_cnt=0, lane index=0, accumulator=0.
- Byte accept: occurs when byte_valid & byte_ready.
  - Write byte_data into accumulator lane idx, i.e. bits [idx*BYTE_W +: BYTE_W].
  - Set keep bit idx.
  - The first byte of a word goes to lane 0 (little-endian, matching the split register mapping).
- Completion: a word completes on accept when idx==BYTES-1 or byte_last==1.
  - On the next edge: copy accumulator (with the new byte) and keep into the output registers; word_last=byte_last; word_valid=1.
  - Reset idx to 0; clear accumulator and keep.
  - Lanes not written in a partial word output as 0 with keep=0.
- Non-completing accept: idx increments; outputs are untouched.
- Latency: word_valid rises exactly 1 cycle after the completing byte is accepted.
- byte_ready = ~word_valid | word_ready.
  - Combinational, independent of byte_valid.
  - With word_ready held at 1 the packer accepts one byte per cycle with no bubbles.
- Output hold: while word_valid & ~word_ready, word_data, word_keep and word_last hold stable and byte_ready=0 (no accumulation during the stall).
- Handoff: when word_valid & word_ready, word_cnt increments by 1 (wraps from all-ones to 0).
  - If no new word completes in the same cycle, word_valid drops next cycle.
  - If a new word completes in the same cycle, the output registers reload and word_valid stays 1 (back-to-back).
- byte_last on lane 0 emits keep=0001 with only lane 0 populated.
- byte_last is ignored when byte_valid=0.
- Reset mid-word drops the partial word. Reset while a word is pending drops it without counting it.

Decomposition:
- Shared package holds the default constants (BYTE_W=8, BYTES=4) and a keep-mask helper function returning the lane-idx one-hot.
- One natural sub-module: byte_word_packer_out_reg. It is the output holding register with valid/ready, reused later for the unpacker.
- The accumulator and index logic stay in the top.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> word_valid=0, byte_ready=1 and word_cnt=0 immediately, without waiting for a clock edge.
- Full-word pack: word_ready=1; send 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44: word_data=0x44332211, keep=1111, last=0, valid for 1 cycle; word_cnt=1.
- Partial flush: send 0xAA, then 0xBB with byte_last=1 -> word_data=0x0000BBAA, keep=0011, last=1; the next byte lands in lane 0.
- Backpressure: hold word_ready=0 after a full word; offer 0x55 -> byte_ready=0 and the output is stable for 5 cycles. Release word_ready -> handoff, then 0x55 is accepted into lane 0.
- Streaming: word_ready=1, 12 continuous bytes 0x01..0x0C -> words 0x04030201, 0x08070605, 0x0C0B0A09 with no idle byte cycles; word_cnt=3.
- Counter wrap: with CNT_W=4, hand off 17 words -> word_cnt reads 1.
